// File: rtl/my_register_arbiter_pkg.sv
// Shared types and constants for the two-requester register arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package my_register_pkg;

    // Default slave data width; byte enables are always derived from it
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;

    // Byte-enable pattern driven to the slave on every read
    localparam logic [DEF_BE_W-1:0] BE_ALL = '1;

    // Arbiter sequencing: one grant cycle then one ack cycle per transaction
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

endpackage : my_register_pkg

// File: rtl/my_register_arbiter_if.sv
// Bundle of the requester-side handshakes and the register-slave bus.
// Latency: n/a (wires only).
// Backpressure: requesters hold req and fields stable until their ack.
interface my_register_arbiter_if
    import my_register_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    localparam int BE_W = DATA_W / 8;

    // Requester 0
    logic              req0;
    logic              wr0;
    logic [BE_W-1:0]   be0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    // Requester 1
    logic              req1;
    logic              wr1;
    logic [BE_W-1:0]   be1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    // Status
    logic              busy;

    // Register slave
    logic              chip_select;
    logic              write;
    logic              read;
    logic [BE_W-1:0]   byte_enable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    // Arbiter view
    modport master (
        input  req0, wr0, be0, wdata0,
        input  req1, wr1, be1, wdata1,
        input  readdata,
        output ack0, rdata0, ack1, rdata1, busy,
        output chip_select, write, read, byte_enable, writedata
    );

    // Environment view: requesters plus the slave
    modport slave (
        output req0, wr0, be0, wdata0,
        output req1, wr1, be1, wdata1,
        output readdata,
        input  ack0, rdata0, ack1, rdata1, busy,
        input  chip_select, write, read, byte_enable, writedata
    );

endinterface : my_register_arbiter_if

// File: rtl/my_register_arbiter_rr_pick2.sv
// Two-way round-robin winner select, one-hot grant.
// Latency: combinational.
// Backpressure: none; a lone requester always wins, ptr breaks ties.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    // Tie goes to the requester named by ptr; otherwise whoever is asking
    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | ~ptr);
        grant[1] = req[1] & (~req[0] |  ptr);
    end

endmodule : rr_pick2

// File: rtl/my_register_arbiter.sv
// Round-robin arbiter serialising two req/ack requesters onto one register slave.
// Latency: req seen in IDLE at edge t -> slave strobes in cycle t+1 -> ack in cycle t+2.
// Backpressure: one transaction per 3 cycles; losers wait with req held, nothing latched from them.
module my_register_arbiter
    import my_register_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clock,
    input  logic                  resetn,
    my_register_arbiter_if.master bus
);

    localparam int BE_W = DATA_W / 8;

    // FSM state
    state_t            state_q, state_d;

    // Arbitration bookkeeping
    logic              ptr_q, ptr_d;     // requester favoured on a tie
    logic              sel_q, sel_d;     // current winner
    logic              wr_q, wr_d;       // winner's direction

    // Registered outputs
    logic              cs_q, cs_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0]        req_vec;
    logic [1:0]        grant;

    assign req_vec = {bus.req1, bus.req0};

    rr_pick2 u_pick (
        .req   (req_vec),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Next state and next values of every registered output
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        wr_d     = wr_q;
        cs_d     = 1'b0;
        write_d  = 1'b0;
        read_d   = 1'b0;
        be_d     = '0;
        wd_d     = '0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    // Latch only the winner's fields and strobe the slave next cycle
                    state_d = ST_GRANT;
                    sel_d   = grant[1];
                    wr_d    = grant[1] ? bus.wr1 : bus.wr0;
                    cs_d    = 1'b1;
                    write_d = wr_d;
                    read_d  = ~wr_d;
                    if (wr_d) begin
                        be_d = grant[1] ? bus.be1 : bus.be0;
                    end else begin
                        be_d = '1;
                    end
                    wd_d    = grant[1] ? bus.wdata1 : bus.wdata0;
                end
            end

            ST_GRANT: begin
                // Slave readdata is valid now; keep it for the winner on reads
                state_d = ST_ACK;
                if (!wr_q) begin
                    if (sel_q) begin
                        rdata1_d = bus.readdata;
                    end else begin
                        rdata0_d = bus.readdata;
                    end
                end
                ack0_d = ~sel_q;
                ack1_d =  sel_q;
            end

            ST_ACK: begin
                // Hand the tie-break to the other requester
                state_d = ST_IDLE;
                ptr_d   = ~sel_q;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            ptr_q    <= 1'b0;
            sel_q    <= 1'b0;
            wr_q     <= 1'b0;
            cs_q     <= 1'b0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            be_q     <= '0;
            wd_q     <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            wr_q     <= wr_d;
            cs_q     <= cs_d;
            write_q  <= write_d;
            read_q   <= read_d;
            be_q     <= be_d;
            wd_q     <= wd_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.chip_select = cs_q;
    assign bus.write       = write_q;
    assign bus.read        = read_q;
    assign bus.byte_enable = be_q;
    assign bus.writedata   = wd_q;
    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.busy        = busy_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;

endmodule : my_register_arbiter

// File: tb/tb_my_register_arbiter.sv
// Directed bench for the two-requester register arbiter with a byte-enabled slave model.
// Latency: checks strobe cycle t+1 and ack cycle t+2 after each request.
// Backpressure: exercises contention, back-to-back requests and mid-transaction reset.
module tb_my_register_arbiter;
    import my_register_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    my_register_arbiter_if #(.DATA_W(32)) bus ();

    my_register_arbiter #(.DATA_W(32)) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Lights register slave: combinational read, byte-enabled write, test preload
    logic [31:0] slave_reg;
    logic [31:0] preload;
    logic        preload_en;
    assign bus.readdata = slave_reg;

    always @(posedge clk) begin
        if (preload_en) begin
            slave_reg <= preload;
        end else if (bus.chip_select && bus.write) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byte_enable[b]) slave_reg[b*8 +: 8] <= bus.writedata[b*8 +: 8];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          id;
        bit          wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] preset;
        logic [3:0]  exp_be;
        logic [31:0] exp_reg;
        logic [31:0] exp_rdata0;
        logic [31:0] exp_rdata1;
    } vec_t;

    vec_t vecs[7];

    // One lone transaction, started at a negedge in IDLE
    task automatic do_txn(input vec_t v);
        preload    = v.preset;
        preload_en = 1'b1;
        if (v.id) begin
            bus.req1 = 1'b1; bus.wr1 = v.wr; bus.be1 = v.be; bus.wdata1 = v.wdata;
        end else begin
            bus.req0 = 1'b1; bus.wr0 = v.wr; bus.be0 = v.be; bus.wdata0 = v.wdata;
        end
        @(negedge clk);
        preload_en = 1'b0;
        chk("grant_strobes", {bus.chip_select, bus.write, bus.read}, {1'b1, v.wr, ~v.wr});
        chk("grant_be", bus.byte_enable, v.exp_be);
        chk("grant_wdata", bus.writedata, v.wdata);
        chk("grant_noack_busy", {bus.ack1, bus.ack0, bus.busy}, 3'b001);
        @(negedge clk);
        chk("ack_who", {bus.ack1, bus.ack0}, v.id ? 2'b10 : 2'b01);
        chk("ack_strobes_off", {bus.chip_select, bus.write, bus.read, bus.busy}, 4'b0001);
        chk("ack_rdata0", bus.rdata0, v.exp_rdata0);
        chk("ack_rdata1", bus.rdata1, v.exp_rdata1);
        chk("slave_reg", slave_reg, v.exp_reg);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("idle_after", {bus.busy, bus.ack1, bus.ack0, bus.chip_select}, 4'b0000);
    endtask

    // Ack recorder for multi-transaction sequences; cycle 1 is the cycle after the request
    int ack_n;
    int ack_cyc[8];
    bit ack_id[8];
    bit both_seen;

    task automatic watch(input int want, input int limit);
        ack_n     = 0;
        both_seen = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            preload_en = 1'b0;
            if (bus.ack0 && bus.ack1) both_seen = 1'b1;
            if ((bus.ack0 || bus.ack1) && ack_n < 8) begin
                ack_id[ack_n]  = bus.ack1;
                ack_cyc[ack_n] = c;
                ack_n++;
            end
            if (ack_n >= want) break;
        end
        chk("watch_count", ack_n, want);
    endtask

    initial begin
        vecs[0] = '{id:0, wr:1, be:4'b0011, wdata:32'hDEADBEEF, preset:32'h00000000,
                    exp_be:4'b0011, exp_reg:32'h0000BEEF, exp_rdata0:32'h0, exp_rdata1:32'h0};
        vecs[1] = '{id:1, wr:0, be:4'b0000, wdata:32'h00000000, preset:32'h12345678,
                    exp_be:BE_ALL, exp_reg:32'h12345678, exp_rdata0:32'h0, exp_rdata1:32'h12345678};
        vecs[2] = '{id:0, wr:0, be:4'b0101, wdata:32'h5555AAAA, preset:32'hCAFEF00D,
                    exp_be:BE_ALL, exp_reg:32'hCAFEF00D, exp_rdata0:32'hCAFEF00D, exp_rdata1:32'h12345678};
        vecs[3] = '{id:1, wr:1, be:4'b1100, wdata:32'hA5A55A5A, preset:32'h11223344,
                    exp_be:4'b1100, exp_reg:32'hA5A53344, exp_rdata0:32'hCAFEF00D, exp_rdata1:32'h12345678};
        vecs[4] = '{id:0, wr:1, be:4'b1001, wdata:32'h12345678, preset:32'h00000000,
                    exp_be:4'b1001, exp_reg:32'h12000078, exp_rdata0:32'hCAFEF00D, exp_rdata1:32'h12345678};
        vecs[5] = '{id:1, wr:1, be:4'b0000, wdata:32'hFFFFFFFF, preset:32'h87654321,
                    exp_be:4'b0000, exp_reg:32'h87654321, exp_rdata0:32'hCAFEF00D, exp_rdata1:32'h12345678};
        vecs[6] = '{id:1, wr:0, be:4'b0011, wdata:32'h0000FFFF, preset:32'h0BADBEEF,
                    exp_be:BE_ALL, exp_reg:32'h0BADBEEF, exp_rdata0:32'hCAFEF00D, exp_rdata1:32'h0BADBEEF};

        // Reset held for two edges
        resetn     = 1'b0;
        preload    = 32'h0;
        preload_en = 1'b1;
        bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.be0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.be1 = '0; bus.wdata1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload_en = 1'b0;
        chk("rst_ctrl", {bus.chip_select, bus.write, bus.read, bus.ack0, bus.ack1, bus.busy}, 6'b0);
        chk("rst_be_wd", {bus.byte_enable, bus.writedata}, 36'h0);
        chk("rst_rdata", {bus.rdata0, bus.rdata1}, 64'h0);
        resetn = 1'b1;

        // Lone transactions from the table
        for (int i = 0; i < 7; i++) do_txn(vecs[i]);

        // Contention: both read and hold for four transactions; pointer is 0 here
        preload    = 32'h13579BDF;
        preload_en = 1'b1;
        bus.req0 = 1'b1; bus.wr0 = 1'b0;
        bus.req1 = 1'b1; bus.wr1 = 1'b0;
        watch(4, 20);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("contend_order", ack_id[i], i % 2);
            chk("contend_cycle", ack_cyc[i], 2 + 3 * i);
        end
        chk("contend_both_ack", both_seen, 1'b0);
        @(negedge clk);
        chk("contend_rdata", {bus.rdata0, bus.rdata1}, {32'h13579BDF, 32'h13579BDF});

        // Mid-transaction reset: move pointer to 1, then abort a read in GRANT
        do_txn('{id:0, wr:1, be:4'hF, wdata:32'h24682468, preset:32'h0, exp_be:4'hF,
                 exp_reg:32'h24682468, exp_rdata0:32'h13579BDF, exp_rdata1:32'h13579BDF});
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.be1 = 4'hF;
        @(negedge clk);
        chk("midrst_grant", {bus.chip_select, bus.read}, 2'b11);
        resetn   = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {bus.chip_select, bus.write, bus.read, bus.ack0, bus.ack1, bus.busy}, 6'b0);
        chk("midrst_rdata", {bus.rdata0, bus.rdata1}, 64'h0);
        resetn = 1'b1;
        @(negedge clk);
        chk("midrst_no_ack", {bus.ack1, bus.ack0, bus.busy}, 3'b000);
        preload    = 32'h0F1E2D3C;
        preload_en = 1'b1;
        bus.req0 = 1'b1; bus.wr0 = 1'b0;
        bus.req1 = 1'b1; bus.wr1 = 1'b0;
        watch(1, 6);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("midrst_ptr_winner", ack_id[0], 1'b0);
        chk("midrst_first_cycle", ack_cyc[0], 2);
        @(negedge clk);
        chk("midrst_rdata_after", {bus.rdata0, bus.rdata1}, {32'h0F1E2D3C, 32'h0});

        // Back-to-back: requester 0 keeps req high through its ack
        preload    = 32'h0;
        preload_en = 1'b1;
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.be0 = 4'b0100; bus.wdata0 = 32'h00AB0000;
        watch(2, 12);
        bus.req0 = 1'b0;
        chk("b2b_ids", {ack_id[0], ack_id[1]}, 2'b00);
        chk("b2b_first", ack_cyc[0], 2);
        chk("b2b_second", ack_cyc[1], 5);
        chk("b2b_both_ack", both_seen, 1'b0);
        @(negedge clk);
        chk("b2b_slave", slave_reg, 32'h00AB0000);
        chk("b2b_rdata0_held", bus.rdata0, 32'h0F1E2D3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_my_register_arbiter
